// File: rtl/grf_pkg.sv
// Shared defaults and helpers for the multi-port general register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grf_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_NREG   = 32;

  // LSB position of port k inside a flattened bus of w-bit lanes.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register busy scoreboard: issue claims a destination, writeback releases it.
// Latency: claims and releases become visible in busy_vec one cycle later.
// Backpressure: none; every claim and release is accepted.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   wr_en, wr_addr        writeback ports; each enabled write releases its register
//   claim_en, claim_addr  destination being issued this cycle
//   busy_vec              registered busy state, bit i = register i busy
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W   = GRF_ADDR_W,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR*ADDR_W-1:0]   wr_addr,
  input  logic                    claim_en,
  input  logic [ADDR_W-1:0]       claim_addr,
  output logic [(2**ADDR_W)-1:0]  busy_vec
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] release_hit;

  always_comb begin
    release_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        release_hit[wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] = 1'b1;
      end
    end
  end

  // Claim has priority over release so a newly issued producer is not lost
  // when an older producer of the same register writes back this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ZERO_REG != 0 && i == 0) begin
          busy_vec[i] <= 1'b0;
        end else if (claim_en && claim_addr == ADDR_W'(i)) begin
          busy_vec[i] <= 1'b1;
        end else if (release_hit[i]) begin
          busy_vec[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with same-cycle write bypass and busy scoreboard.
// Latency: reads combinational (zero cycles); writes and claims land at the next rising edge.
// Backpressure: none; all reads, writes and claims are accepted every cycle.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   rd_addr / rd_data     NRD combinational read ports, flattened per port
//   rd_busy               per read port: value not yet produced
//   wr_en/wr_addr/wr_data NWR write ports; higher port index wins on conflicts
//   claim_en/claim_addr   mark a destination busy
//   busy_vec              registered scoreboard state
// Build option: define GRF_TRACE_EN to print one line per committed write.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W   = GRF_DATA_W,
  parameter int ADDR_W   = GRF_ADDR_W,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR*ADDR_W-1:0]   wr_addr,
  input  logic [NWR*DATA_W-1:0]   wr_data,
  input  logic                    claim_en,
  input  logic [ADDR_W-1:0]       claim_addr,
  output logic [(2**ADDR_W)-1:0]  busy_vec
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NWR-1:0]    wr_win;

  // A port commits only if it is enabled, not a discarded zero-register
  // write, and no higher-indexed port targets the same address.
  always_comb begin
    wr_win = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_win[j] = wr_en[j];
      if (ZERO_REG != 0 && wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == '0) begin
        wr_win[j] = 1'b0;
      end
      for (int h = j + 1; h < NWR; h++) begin
        if (wr_en[h] &&
            wr_addr[slice_lo(h, ADDR_W) +: ADDR_W] == wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]) begin
          wr_win[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_win[j]) begin
          regs[wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] <= wr_data[slice_lo(j, DATA_W) +: DATA_W];
`ifdef GRF_TRACE_EN
          $display("$%0d <= %h", wr_addr[slice_lo(j, ADDR_W) +: ADDR_W],
                   wr_data[slice_lo(j, DATA_W) +: DATA_W]);
`endif
        end
      end
    end
  end

  // Read muxes: ascending port scan so the highest matching write port
  // supplies the bypass value, matching the commit priority above.
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rdat;
  logic              hit;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    hit     = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra   = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
      rdat = regs[ra];
      hit  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == ra) begin
          rdat = wr_data[slice_lo(j, DATA_W) +: DATA_W];
          hit  = 1'b1;
        end
      end
      if (ZERO_REG != 0 && ra == '0) begin
        rd_data[slice_lo(k, DATA_W) +: DATA_W] = '0;
        rd_busy[k] = 1'b0;
      end else begin
        rd_data[slice_lo(k, DATA_W) +: DATA_W] = rdat;
        rd_busy[k] = busy_vec[ra] & ~hit;
      end
    end
  end

  grf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_grf_mp.sv
// Directed self-checking bench for grf_mp (ZERO_REG=1 main instance, ZERO_REG=0 companion).
// Latency: n/a.
// Backpressure: n/a.
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_z;
  logic [1:0]  rd_busy, rd_busy_z;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [31:0] busy_vec, busy_vec_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grf_mp #(.ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec)
  );

  grf_mp #(.ZERO_REG(0)) dut_z (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); rd_addr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    for (int a = 0; a < grf_pkg::GRF_NREG; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (rd_data !== 64'd0) begin
        errors++;
        $display("FAIL reset_rd_data addr=%0d got=%h exp=%h", a, rd_data, 64'd0);
      end
    end
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL reset_busy_vec got=%h exp=%h", busy_vec, 32'd0);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_rd_busy got=%b exp=00", rd_busy);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
    rd_addr = {5'd5, 5'd3};
    #1;
    checks++;
    if (rd_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_port1 got=%h exp=%h", rd_data[63:32], 32'hDEADBEEF);
    end
    checks++;
    if (rd_data[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL bypass_unrelated_port0 got=%h exp=%h", rd_data[31:0], 32'd0);
    end
    tick(); idle(); #1;
    checks++;
    if (rd_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stored_r5 got=%h exp=%h", rd_data[63:32], 32'hDEADBEEF);
    end
  endtask

  task automatic test_conflict();
    idle();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22222222, 32'h11111111};
    rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rd_data !== {32'h22222222, 32'h22222222}) begin
      errors++;
      $display("FAIL conflict_bypass got=%h exp=%h", rd_data, {32'h22222222, 32'h22222222});
    end
    tick(); idle(); #1;
    checks++;
    if (rd_data !== {32'h22222222, 32'h22222222}) begin
      errors++;
      $display("FAIL conflict_stored got=%h exp=%h", rd_data, {32'h22222222, 32'h22222222});
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h12345678};
    claim_en = 1'b1; claim_addr = 5'd0;
    rd_addr = {5'd7, 5'd0};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'd0 || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_bypass got=%h/%b exp=0/0", rd_data[31:0], rd_busy[0]);
    end
    checks++;
    if (rd_data_z[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL nozero_bypass got=%h exp=%h", rd_data_z[31:0], 32'h12345678);
    end
    tick(); idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'd0 || busy_vec[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_stored got=%h busy0=%b exp=0/0", rd_data[31:0], busy_vec[0]);
    end
    checks++;
    if (rd_data_z[31:0] !== 32'h12345678 || busy_vec_z[0] !== 1'b1) begin
      errors++;
      $display("FAIL nozero_stored got=%h busy0=%b exp=%h/1", rd_data_z[31:0], busy_vec_z[0], 32'h12345678);
    end
    // clear the companion's busy bit so later busy_vec values stay simple
    wr_en = 2'b01; wr_addr = '0; wr_data = '0;
    tick(); idle(); #1;
  endtask

  task automatic test_scoreboard();
    idle();
    claim_en = 1'b1; claim_addr = 5'd9; rd_addr = {5'd0, 5'd9};
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_claim_rd_busy got=%b exp=0", rd_busy[0]);
    end
    tick(); idle(); #1;
    checks++;
    if (busy_vec !== (32'd1 << 9) || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL claim9 busy_vec=%h rd_busy=%b exp=%h/1", busy_vec, rd_busy[0], 32'd1 << 9);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'hA5A5A5A5};
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL release9_bypass rd_busy=%b data=%h exp=0/%h", rd_busy[0], rd_data[31:0], 32'hA5A5A5A5);
    end
    tick(); idle(); #1;
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL release9 busy_vec=%h exp=%h", busy_vec, 32'd0);
    end
    // release of a register that is not busy has no effect
    wr_en = 2'b10; wr_addr = {5'd10, 5'd0}; wr_data = {32'h0000000A, 32'd0};
    tick(); idle(); #1;
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL release_idle busy_vec=%h exp=%h", busy_vec, 32'd0);
    end
    // claim and release of the same register: the claim wins
    claim_en = 1'b1; claim_addr = 5'd9;
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h00000099, 32'd0};
    tick(); idle(); #1;
    checks++;
    if (busy_vec !== (32'd1 << 9) || rd_data[31:0] !== 32'h00000099) begin
      errors++;
      $display("FAIL claim_and_write9 busy_vec=%h data=%h exp=%h/%h", busy_vec, rd_data[31:0], 32'd1 << 9, 32'h99);
    end
    // claim of an already-busy register keeps it busy
    claim_en = 1'b1; claim_addr = 5'd9;
    tick(); idle(); #1;
    checks++;
    if (busy_vec !== (32'd1 << 9)) begin
      errors++;
      $display("FAIL reclaim9 busy_vec=%h exp=%h", busy_vec, 32'd1 << 9);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_busy;
    exp_busy = (32'd1 << 9) | (32'd1 << 12) | (32'd1 << 14);
    idle();
    claim_en = 1'b1; claim_addr = 5'd12;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd13}; wr_data = {32'd0, 32'h00000001};
    tick();
    idle();
    claim_en = 1'b1; claim_addr = 5'd14;
    wr_en = 2'b10; wr_addr = {5'd15, 5'd0}; wr_data = {32'h00000002, 32'd0};
    tick(); idle();
    rd_addr = {5'd15, 5'd13};
    #1;
    checks++;
    if (busy_vec !== exp_busy || rd_data !== {32'd2, 32'd1}) begin
      errors++;
      $display("FAIL pre_reset busy_vec=%h data=%h exp=%h/%h", busy_vec, rd_data, exp_busy, {32'd2, 32'd1});
    end
    reset = 1'b1;
    claim_en = 1'b1; claim_addr = 5'd16;
    wr_en = 2'b11; wr_addr = {5'd17, 5'd13}; wr_data = {32'h00000003, 32'h00000004};
    tick();
    reset = 1'b0; idle();
    #1;
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_busy busy_vec=%h exp=%h", busy_vec, 32'd0);
    end
    rd_addr = {5'd17, 5'd13};
    #1;
    checks++;
    if (rd_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_cycle_write_dropped got=%h exp=%h", rd_data, 64'd0);
    end
    rd_addr = {5'd15, 5'd5};
    #1;
    checks++;
    if (rd_data !== 64'd0) begin
      errors++;
      $display("FAIL post_reset_regs got=%h exp=%h", rd_data, 64'd0);
    end
    rd_addr = {5'd9, 5'd7};
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_regs2 got=%h busy=%b exp=0/00", rd_data, rd_busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0;
    idle();
    test_reset();
    test_bypass();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
